lcd_msg_writer: RTL and testbench
=================================

Name: lcd_msg_writer

Overview:
Parametrised HD44780 text writer for the instruction-display path. It accepts an opcode and an operand value over a valid/ready handshake. It then redraws the whole panel: clear, then per row a DDRAM address command followed by COLS characters. Row 0 shows the opcode mnemonic and row 1 shows the operand in hex. It sits between the LCD init sequencer (init_done) and the LCD pins, and replaces the fixed 16x2, opcode-only, button-driven writer.

Parameters:
COLS, 16, characters per row (4..40)
ROWS, 2, display rows (1, 2 or 4)
VALUE_W, 16, operand width in bits; shown as ceil(VALUE_W/4) uppercase hex digits
EN_PULSE_CYC, 20, clocks lcd_en is held high per transfer
CHAR_WAIT_CYC, 2500, post-pulse wait for data and address commands (~50 us at 50 MHz)
CLEAR_WAIT_CYC, 100000, post-pulse wait for the clear command (~2 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain, asynchronous assert, active-high
init_done  in  1  LCD power-up init complete; sampled only in S_WAIT_INIT
req_valid  in  1  request present
req_ready  out  1  high only in S_IDLE
opcode  in  3  opcode; latched on accept
value  in  VALUE_W  operand; latched on accept
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  constant 0 (write only)
lcd_en  out  1  LCD enable strobe
lcd_data  out  8  LCD bus
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse when a redraw completes

Behaviour:
- Reset values: state S_WAIT_INIT; lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=8'h00, req_ready=0, busy=0, done=0. Latched opcode and value are cleared to 0.
- Reset mid-transfer: lcd_en drops asynchronously and the FSM restarts at S_WAIT_INIT. No partial row is resumed.
- States: S_WAIT_INIT, S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_DONE.
- S_WAIT_INIT -> S_IDLE when init_done=1.
- S_IDLE: req_ready=1. Accept occurs when req_valid && req_ready. On accept, latch opcode and value, queue the clear command, and go to S_SETUP.
- Each transfer is three phases:
  - S_SETUP, 1 cycle: drive lcd_rs/lcd_data, lcd_en=0.
  - S_PULSE: lcd_en=1 for exactly EN_PULSE_CYC cycles.
  - S_WAIT: lcd_en=0 for CLEAR_WAIT_CYC cycles after the clear, otherwise CHAR_WAIT_CYC cycles.
  - lcd_rs and lcd_data stay stable from S_SETUP through the end of S_WAIT.
- Transfer order:
  - Clear (rs=0, 8'h01).
  - For r = 0..ROWS-1: address command (rs=0, 8'h80 | base[r]), then columns c = 0..COLS-1 as data (rs=1).
  - base = {8'h00, 8'h40, COLS, 8'h40+COLS}.
- Row 0 text: mnemonic left-justified and space-padded.
  - 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLR, 111 DPL.
- Row 1 text: "V=" then the hex digits, MSB digit first, space-padded. If VALUE_W is not a multiple of 4, the top digit is zero-extended.
- Rows 2..3 text: all spaces (8'h20).
- Text longer than COLS is truncated at COLS. No wrap-around into the next row.
- After the final character's S_WAIT, go to S_DONE: done=1 for 1 cycle, busy=0, then S_IDLE.
- Latency from the accept edge to the done-high cycle: L = (1+EN_PULSE_CYC+CLEAR_WAIT_CYC) + ROWS*(COLS+1)*(1+EN_PULSE_CYC+CHAR_WAIT_CYC) + 1.
- req_valid while busy is ignored (req_ready=0). The requester must hold req_valid and its data until accepted.
- Counter widths: sized by $clog2 of the largest wait/index. No overflow is permitted at any parameter within range.

Optional Feature:
LCD_SKIP_SAME_EN:
- Defined: the block keeps a shadow of the last completed {opcode, value}, plus a valid flag cleared by reset.
  - An accepted request equal to the shadow while the flag is set performs no bus activity: S_IDLE -> S_DONE directly, and done pulses 2 cycles after the accept edge.
  - A reset mid-redraw leaves the flag clear.
- Undefined: every accepted request performs a full redraw.

Test Plan:
- Reset, init_done=1 at cycle 10 -> req_ready rises one cycle later; lcd_en, lcd_data and done are all 0 before that.
- Defaults, opcode=3'b010, value=16'h1A2F -> bus sequence: 01, 80, "ADDI"+12 spaces, C0, "V=1A2F"+10 spaces. done pulses exactly 185736 cycles after accept; each lcd_en pulse is high for 20 cycles.
- COLS=20, ROWS=4, opcode=3'b101, value=0 -> address commands 80, C0, 94, D4; rows 2-3 are 20×8'h20; row 1 reads "V=0000".
- req_valid pulsed with opcode=3'b000 during a redraw -> not accepted, and the display text is unchanged. After done, opcode=3'b000 is accepted and shows "LOAD".
- Assert rst during the row-1 character pulses -> lcd_en is low in the same cycle. After init_done, a new request performs a full clear-first redraw.
- LCD_SKIP_SAME_EN, the same {3'b011, 16'h0005} sent twice -> the second request gives no lcd_en activity and done 2 cycles after accept. A third request with value 16'h0006 performs a full redraw.

Source files
------------

// File: rtl/lcd_msg_writer.sv
// lcd_msg_writer: HD44780 full-panel redraw, opcode mnemonic on row 0, hex operand on row 1; optional LCD_SKIP_SAME_EN.
// Latency: accept edge to done = (1+EN+CLEAR) + ROWS*(COLS+1)*(1+EN+CHAR) + 1 clocks (2 when a repeat is skipped).
// Backpressure: req_ready only in S_IDLE; requester holds req_valid/opcode/value until accepted.
module lcd_msg_writer #(
  parameter int COLS           = 16,
  parameter int ROWS           = 2,
  parameter int VALUE_W        = 16,
  parameter int EN_PULSE_CYC   = 20,
  parameter int CHAR_WAIT_CYC  = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         opcode,
  input  logic [VALUE_W-1:0] value,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic [7:0]         lcd_data,
  output logic               busy,
  output logic               done
);

  localparam int HEX_DIGITS = (VALUE_W + 3) / 4;
  localparam int MAX_WAIT_A = (CLEAR_WAIT_CYC > CHAR_WAIT_CYC) ? CLEAR_WAIT_CYC : CHAR_WAIT_CYC;
  localparam int MAX_WAIT   = (MAX_WAIT_A > EN_PULSE_CYC) ? MAX_WAIT_A : EN_PULSE_CYC;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);
  localparam int COL_W      = $clog2(COLS + 1);
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {S_WAIT_INIT, S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_is_clear;
  logic [2:0]         r_opcode;
  logic [VALUE_W-1:0] r_value;
`ifdef LCD_SKIP_SAME_EN
  logic               r_skip;
  logic               r_shadow_vld;
  logic [2:0]         r_shadow_op;
  logic [VALUE_W-1:0] r_shadow_val;
`endif

  logic [CNT_W-1:0]   w_wait_last;
  logic               w_last_col;
  logic               w_last_row;
  logic [7:0]         w_char;
  logic [7:0]         w_addr_next;

  function automatic logic [7:0] f_addr(input int row);
    case (row)
      1:       f_addr = 8'hC0;
      2:       f_addr = 8'h80 | 8'(COLS);
      3:       f_addr = 8'h80 | 8'(64 + COLS);
      default: f_addr = 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] f_char(input int row, input int col,
                                        input logic [2:0] op, input logic [VALUE_W-1:0] val);
    logic [31:0]             mn;
    logic [4*HEX_DIGITS-1:0] ext;
    logic [3:0]              nib;
    int                      dig;
    f_char = 8'h20;
    ext = '0;
    ext[VALUE_W-1:0] = val;
    dig = col - 2;
    case (op)
      3'd0:    mn = "LOAD";
      3'd1:    mn = "ADD ";
      3'd2:    mn = "ADDI";
      3'd3:    mn = "SUB ";
      3'd4:    mn = "SUBI";
      3'd5:    mn = "MUL ";
      3'd6:    mn = "CLR ";
      default: mn = "DPL ";
    endcase
    if (row == 0 && col < 4) begin
      f_char = mn[8*(3-col) +: 8];
    end else if (row == 1) begin
      if (col == 0) begin
        f_char = 8'h56;
      end else if (col == 1) begin
        f_char = 8'h3D;
      end else if (dig < HEX_DIGITS) begin
        // Top digit is zero-extended when VALUE_W is not a multiple of 4.
        nib = 4'(ext >> (4 * (HEX_DIGITS - 1 - dig)));
        f_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end
    end
  endfunction

  assign lcd_rw      = 1'b0;
  assign w_wait_last = r_is_clear ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CHAR_WAIT_CYC - 1);
  assign w_last_col  = (r_col == COL_W'(COLS));
  assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
  // r_col is the column about to be sent when the address slot (0) is already done.
  assign w_char      = f_char(int'(r_row), int'(r_col), r_opcode, r_value);
  assign w_addr_next = r_is_clear ? f_addr(0) : f_addr(int'(r_row) + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_WAIT_INIT;
      r_cnt      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_is_clear <= 1'b0;
      r_opcode   <= '0;
      r_value    <= '0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= 8'h00;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef LCD_SKIP_SAME_EN
      r_skip       <= 1'b0;
      r_shadow_vld <= 1'b0;
      r_shadow_op  <= '0;
      r_shadow_val <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_WAIT_INIT: begin
          if (init_done) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            r_opcode  <= opcode;
            r_value   <= value;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef LCD_SKIP_SAME_EN
            if (r_shadow_vld && opcode == r_shadow_op && value == r_shadow_val) begin
              r_skip  <= 1'b1;
              r_state <= S_DONE;
            end else
`endif
            begin
              r_state    <= S_SETUP;
              r_is_clear <= 1'b1;
              r_row      <= '0;
              r_col      <= '0;
              r_cnt      <= '0;
              lcd_rs     <= 1'b0;
              lcd_data   <= 8'h01;
            end
          end
        end
        S_SETUP: begin
          r_state <= S_PULSE;
          lcd_en  <= 1'b1;
          r_cnt   <= '0;
        end
        S_PULSE: begin
          if (r_cnt == CNT_W'(EN_PULSE_CYC - 1)) begin
            lcd_en  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt <= '0;
            if (r_is_clear) begin
              r_is_clear <= 1'b0;
              lcd_rs     <= 1'b0;
              lcd_data   <= w_addr_next;
              r_state    <= S_SETUP;
            end else if (!w_last_col) begin
              r_col    <= r_col + 1'b1;
              lcd_rs   <= 1'b1;
              lcd_data <= w_char;
              r_state  <= S_SETUP;
            end else if (!w_last_row) begin
              r_row    <= r_row + 1'b1;
              r_col    <= '0;
              lcd_rs   <= 1'b0;
              lcd_data <= w_addr_next;
              r_state  <= S_SETUP;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
`ifdef LCD_SKIP_SAME_EN
          // A skipped request spends two cycles here so done lands 2 cycles after accept.
          if (r_skip) begin
            r_skip <= 1'b0;
          end else
`endif
          begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
`ifdef LCD_SKIP_SAME_EN
            r_shadow_vld <= 1'b1;
            r_shadow_op  <= r_opcode;
            r_shadow_val <= r_value;
`endif
          end
        end
        default: r_state <= S_WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Bench for lcd_msg_writer: small panel/timing parameters, captured LCD transfers vs a text-level reference model.
module tb_lcd_msg_writer;

  localparam int COLS    = 5;
  localparam int ROWS    = 4;
  localparam int VALUE_W = 13;
  localparam int EN      = 3;
  localparam int CHW     = 5;
  localparam int CLW     = 12;
  localparam int HD      = (VALUE_W + 3) / 4;
  localparam int LAT     = (1 + EN + CLW) + ROWS * (COLS + 1) * (1 + EN + CHW) + 1;
`ifdef LCD_SKIP_SAME_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic               clk, rst, init_done, req_valid, req_ready;
  logic [2:0]         opcode;
  logic [VALUE_W-1:0] value;
  logic               lcd_rs, lcd_rw, lcd_en, busy, done;
  logic [7:0]         lcd_data;

  lcd_msg_writer #(
    .COLS(COLS), .ROWS(ROWS), .VALUE_W(VALUE_W),
    .EN_PULSE_CYC(EN), .CHAR_WAIT_CYC(CHW), .CLEAR_WAIT_CYC(CLW)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .value(value), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Monitor: one captured entry per lcd_en pulse, with its width and setup/hold stability.
  logic [8:0] cap_q[$];
  int         wid_q[$];
  int         bad_setup = 0;
  int         en_cycles = 0;
  int         en_base = 0;

  initial begin
    logic       prev_en;
    logic [8:0] prev_byte, cur_byte;
    int         cur_w;
    bit         cur_ok;
    prev_en = 1'b0; prev_byte = '0; cur_byte = '0; cur_w = 0; cur_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (lcd_en) en_cycles++;
      if (lcd_en && !prev_en) begin
        cur_byte = {lcd_rs, lcd_data};
        cur_w    = 1;
        cur_ok   = (prev_byte === {lcd_rs, lcd_data});
      end else if (lcd_en) begin
        cur_w++;
        if ({lcd_rs, lcd_data} !== cur_byte) cur_ok = 1'b0;
      end else if (prev_en) begin
        if ({lcd_rs, lcd_data} !== cur_byte) cur_ok = 1'b0;
        cap_q.push_back(cur_byte);
        wid_q.push_back(cur_w);
        if (!cur_ok) bad_setup++;
      end
      prev_en   = lcd_en;
      prev_byte = {lcd_rs, lcd_data};
    end
  end

  // Reference model: panel text built from the mnemonic table and hex digits.
  string      mn[8] = '{"LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLR", "DPL"};
  string      hexs = "0123456789ABCDEF";
  logic [8:0] exp_q[$];
  bit         exp_skip;
  bit         m_sh_vld = 1'b0;
  logic [2:0] m_sh_op = '0;
  logic [VALUE_W-1:0] m_sh_val = '0;

  function automatic void build_exp(input logic [2:0] op, input logic [VALUE_W-1:0] val);
    logic [7:0] txt[$];
    int         base[4];
    base = '{0, 'h40, COLS, 'h40 + COLS};
    exp_skip = SKIP_EN && m_sh_vld && (m_sh_op == op) && (m_sh_val == val);
    exp_q.delete();
    if (exp_skip) return;
    exp_q.push_back(9'h001);
    for (int r = 0; r < ROWS; r++) begin
      txt.delete();
      if (r == 0) for (int j = 0; j < mn[op].len(); j++) txt.push_back(mn[op][j]);
      if (r == 1) begin
        txt.push_back("V");
        txt.push_back("=");
        for (int d = HD - 1; d >= 0; d--) txt.push_back(hexs[(int'(val) >> (4 * d)) & 15]);
      end
      exp_q.push_back({1'b0, 8'h80 | 8'(base[r])});
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, (c < txt.size()) ? txt[c] : 8'h20});
    end
  endfunction

  task automatic send(input logic [2:0] op, input logic [VALUE_W-1:0] val);
    int t = 0;
    while (!req_ready && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL send_ready: req_ready=%b required 1", req_ready);
    end
    opcode = op; value = val; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cap_q.delete(); wid_q.delete(); bad_setup = 0; en_base = en_cycles;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done && lat < 3000);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; init_done = 1'b0; req_valid = 1'b0; opcode = '0; value = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (lcd_en !== 1'b0)     begin n_err++; $display("FAIL rst_en: got %b required 0", lcd_en); end
    n_cmp++; if (lcd_rs !== 1'b0)     begin n_err++; $display("FAIL rst_rs: got %b required 0", lcd_rs); end
    n_cmp++; if (lcd_rw !== 1'b0)     begin n_err++; $display("FAIL rst_rw: got %b required 0", lcd_rw); end
    n_cmp++; if (lcd_data !== 8'h00)  begin n_err++; $display("FAIL rst_data: got %h required 00", lcd_data); end
    n_cmp++; if (req_ready !== 1'b0)  begin n_err++; $display("FAIL rst_ready: got %b required 0", req_ready); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL rst_done: got %b required 0", done); end
    rst = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b0 || lcd_en !== 1'b0 || lcd_data !== 8'h00 || done !== 1'b0) begin
        n_err++;
        $display("FAIL pre_init[%0d]: ready=%b en=%b data=%h done=%b required all 0", cyc, req_ready, lcd_en, lcd_data, done);
      end
    end
    @(posedge clk); #1;
    init_done = 1'b1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL init_same_cycle: ready=%b required 0", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL init_next_cycle: ready=%b required 1", req_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL idle_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_redraw_random;
    logic [2:0]         op;
    logic [VALUE_W-1:0] val;
    int                 lat, badw;
    for (int i = 0; i < 6; i++) begin
      op  = (i == 0) ? 3'b010 : 3'($urandom_range(7));
      val = (i == 0) ? VALUE_W'(16'h1A2F) : VALUE_W'($urandom);
      build_exp(op, val);
      send(op, val);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL rand_busy[%0d]: busy=%b required 1", i, busy); end
      wait_done(lat);
      n_cmp++;
      if (lat != (exp_skip ? 2 : LAT)) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, exp_skip ? 2 : LAT); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_done[%0d]: busy=%b required 0", i, busy); end
      n_cmp++;
      if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_len[%0d]: got %0d transfers required %0d", i, cap_q.size(), exp_q.size()); end
      foreach (exp_q[k]) begin
        n_cmp++;
        if (k >= cap_q.size() || cap_q[k] !== exp_q[k]) begin
          n_err++; $display("FAIL rand_byte[%0d][%0d]: got %h required %h", i, k, (k < cap_q.size()) ? cap_q[k] : 9'h1FF, exp_q[k]);
        end
      end
      badw = 0;
      foreach (wid_q[k]) if (wid_q[k] != EN) badw++;
      n_cmp++;
      if (badw != 0 || bad_setup != 0) begin
        n_err++; $display("FAIL rand_pulse[%0d]: %0d bad widths, %0d unstable transfers, required 0/0", i, badw, bad_setup);
      end
      m_sh_vld = 1'b1; m_sh_op = op; m_sh_val = val;
    end
  endtask

  task automatic test_busy_ignore;
    logic [VALUE_W-1:0] val;
    int                 lat;
    val = VALUE_W'($urandom) ^ m_sh_val;
    val[0] = ~m_sh_val[0];
    build_exp(3'b110, val);
    send(3'b110, val);
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: ready=%b required 0", req_ready); end
    opcode = 3'b000; value = '0; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done(lat);
    n_cmp++;
    if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL busy_len: got %0d transfers required %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_cmp++;
      if (k >= cap_q.size() || cap_q[k] !== exp_q[k]) begin
        n_err++; $display("FAIL busy_byte[%0d]: got %h required %h", k, (k < cap_q.size()) ? cap_q[k] : 9'h1FF, exp_q[k]);
      end
    end
    m_sh_vld = 1'b1; m_sh_op = 3'b110; m_sh_val = val;
    en_base = en_cycles;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (en_cycles != en_base || busy !== 1'b0) begin
      n_err++; $display("FAIL busy_dropped: en cycles %0d busy=%b after done, required 0/0", en_cycles - en_base, busy);
    end
    build_exp(3'b000, val);
    send(3'b000, val);
    wait_done(lat);
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL load_latency: got %0d required %0d", lat, LAT); end
    foreach (exp_q[k]) begin
      n_cmp++;
      if (k >= cap_q.size() || cap_q[k] !== exp_q[k]) begin
        n_err++; $display("FAIL load_byte[%0d]: got %h required %h", k, (k < cap_q.size()) ? cap_q[k] : 9'h1FF, exp_q[k]);
      end
    end
    m_sh_vld = 1'b1; m_sh_op = 3'b000; m_sh_val = val;
  endtask

  task automatic test_reset_mid;
    logic [2:0]         op;
    logic [VALUE_W-1:0] val;
    int                 t, lat;
    op = 3'b100; val = VALUE_W'($urandom);
    send(op, val);
    t = 0;
    while (!(cap_q.size() == 2 + COLS + 1 && lcd_en) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (!(cap_q.size() == 2 + COLS + 1 && lcd_en === 1'b1)) begin
      n_err++; $display("FAIL mid_reach: transfers=%0d en=%b, required %0d and 1", cap_q.size(), lcd_en, 2 + COLS + 1);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (lcd_en !== 1'b0) begin n_err++; $display("FAIL mid_en_async: en=%b required 0", lcd_en); end
    n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL mid_flags: busy=%b ready=%b required 0/0", busy, req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_sh_vld = 1'b0;
    build_exp(op, val);
    send(op, val);
    wait_done(lat);
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL post_rst_latency: got %0d required %0d", lat, LAT); end
    n_cmp++;
    if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL post_rst_len: got %0d required %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_cmp++;
      if (k >= cap_q.size() || cap_q[k] !== exp_q[k]) begin
        n_err++; $display("FAIL post_rst_byte[%0d]: got %h required %h", k, (k < cap_q.size()) ? cap_q[k] : 9'h1FF, exp_q[k]);
      end
    end
    m_sh_vld = 1'b1; m_sh_op = op; m_sh_val = val;
  endtask

  task automatic test_back_to_back;
    logic [2:0]         ops[3];
    logic [VALUE_W-1:0] vals[3];
    int                 lat;
    ops  = '{3'b011, 3'b011, 3'b011};
    vals = '{VALUE_W'(5), VALUE_W'(5), VALUE_W'(6)};
    for (int i = 0; i < 3; i++) begin
      build_exp(ops[i], vals[i]);
      send(ops[i], vals[i]);
      wait_done(lat);
      n_cmp++;
      if (lat != (exp_skip ? 2 : LAT)) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, lat, exp_skip ? 2 : LAT); end
      n_cmp++;
      if (en_cycles - en_base != exp_q.size() * EN) begin
        n_err++; $display("FAIL b2b_en_cycles[%0d]: got %0d required %0d", i, en_cycles - en_base, exp_q.size() * EN);
      end
      foreach (exp_q[k]) begin
        n_cmp++;
        if (k >= cap_q.size() || cap_q[k] !== exp_q[k]) begin
          n_err++; $display("FAIL b2b_byte[%0d][%0d]: got %h required %h", i, k, (k < cap_q.size()) ? cap_q[k] : 9'h1FF, exp_q[k]);
        end
      end
      m_sh_vld = 1'b1; m_sh_op = ops[i]; m_sh_val = vals[i];
    end
  endtask

  initial begin
    test_reset();
    test_redraw_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
